// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT sink/source control blocks.
package fft_ctrl_pkg;

  localparam int unsigned SINK_ERR_W = 2;
  localparam int unsigned GAP_CNT_W  = 8;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } framer_state_t;

  // Avalon-ST error codes as reported by the FFT core
  localparam logic [SINK_ERR_W-1:0] SINK_ERR_NONE           = 2'b00;
  localparam logic [SINK_ERR_W-1:0] SINK_ERR_MISSING_SOP    = 2'b01;
  localparam logic [SINK_ERR_W-1:0] SINK_ERR_MISSING_EOP    = 2'b10;
  localparam logic [SINK_ERR_W-1:0] SINK_ERR_UNEXPECTED_EOP = 2'b11;

endpackage

// File: rtl/fft_sink_framer_if.sv
// Avalon-ST sink bus between the framer (master) and the FFT core (slave).
interface fft_sink_framer_if
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 14
);
  logic                  sink_valid;
  logic                  sink_ready;
  logic                  sink_sop;
  logic                  sink_eop;
  logic [DATA_W-1:0]     sink_real;
  logic [DATA_W-1:0]     sink_imag;
  logic [SINK_ERR_W-1:0] sink_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    output sink_ready
  );
endinterface

// File: rtl/fft_frame_counter.sv
// Sample index within a frame; first/last flags are registered alongside the index.
module fft_frame_counter #(
  parameter int unsigned FFT_LEN = 1024,
  parameter int unsigned LEN_W   = $clog2(FFT_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic is_first,
  output logic is_last
);

  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_next;

  // Power-of-two length, so the natural overflow is the wrap to 0
  always_comb begin
    idx_next = idx;
    if (load) begin
      idx_next = idx + LEN_W'(1);
    end else if (clear) begin
      idx_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      is_first <= 1'b1;
      is_last  <= 1'b0;
    end else begin
      idx      <= idx_next;
      is_first <= (idx_next == '0);
      is_last  <= (idx_next == LEN_W'(FFT_LEN - 1));
    end
  end

endmodule

// File: rtl/fft_sink_framer.sv
// Frames a free-running real sample stream into FFT_LEN-beat Avalon-ST packets
// with backpressure, per-frame mode select, inter-frame gap and drop accounting.
module fft_sink_framer
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FFT_LEN    = 1024,
  parameter int unsigned LEN_W      = $clog2(FFT_LEN),
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 inverse_req,
  input  logic                 clr_status,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  fft_sink_framer_if.master    sink,
  output logic                 inverse,
  output logic [LEN_W:0]       fft_pts,
  output logic                 busy,
  output logic                 overrun,
  output logic [STAT_W-1:0]    drop_count,
  output logic [STAT_W-1:0]    frames_done
);

  framer_state_t        state;
  framer_state_t        state_next;
  logic                 accept;
  logic                 loadable;
  logic                 take;
  logic                 start;
  logic                 drop;
  logic                 eop_done;
  logic                 cnt_first;
  logic                 cnt_last;
  logic [GAP_CNT_W-1:0] gap_cnt;

  assign sink.sink_imag  = '0;
  assign sink.sink_error = SINK_ERR_NONE;
  assign fft_pts         = (LEN_W + 1)'(FFT_LEN);

  fft_frame_counter #(
    .FFT_LEN (FFT_LEN),
    .LEN_W   (LEN_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .clear    (state == ST_IDLE),
    .is_first (cnt_first),
    .is_last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Once the EOP beat is loaded the frame is full: later samples drop until it is accepted
  always_comb begin
    state_next = state;
    take       = 1'b0;
    start      = 1'b0;
    drop       = 1'b0;
    eop_done   = 1'b0;
    accept     = sink.sink_valid & sink.sink_ready;
    loadable   = ~sink.sink_valid | accept;
    case (state)
      ST_IDLE: begin
        if (enable && in_valid) begin
          take       = 1'b1;
          start      = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept && sink.sink_eop) begin
          eop_done   = 1'b1;
          state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else if (in_valid) begin
          if (loadable) begin
            take = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sink.sink_valid <= 1'b0;
      sink.sink_sop   <= 1'b0;
      sink.sink_eop   <= 1'b0;
      sink.sink_real  <= '0;
      inverse         <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      drop_count      <= '0;
      frames_done     <= '0;
      gap_cnt         <= '0;
    end else begin
      if (take) begin
        sink.sink_valid <= 1'b1;
        sink.sink_real  <= in_data;
        sink.sink_sop   <= cnt_first;
        sink.sink_eop   <= cnt_last;
      end else if (accept) begin
        sink.sink_valid <= 1'b0;
      end
      if (start) begin
        inverse <= inverse_req;
      end
      busy    <= (state_next != ST_IDLE);
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_CNT_W'(1) : '0;
      if (eop_done) begin
        frames_done <= frames_done + STAT_W'(1);
      end
      // Clear takes priority over a coincident drop
      if (clr_status) begin
        overrun    <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overrun <= 1'b1;
        if (drop_count != {STAT_W{1'b1}}) begin
          drop_count <= drop_count + STAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_sink_framer.sv
// Scoreboard bench: two framers (gap 0 and gap 4) share randomized stimulus and are
// checked against a frame-level reference model.
module tb_fft_sink_framer;
  localparam int unsigned DW  = 14;
  localparam int unsigned LEN = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic          inv;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          inverse_req;
  logic          clr_status;
  logic          in_valid;
  logic          ready;
  logic [DW-1:0] in_data;

  logic        inverse0, inverse1, busy0, busy1, ovr0, ovr1;
  logic [3:0]  pts0, pts1;
  logic [15:0] drops0, drops1, frames0, frames1;

  int checks = 0;
  int errors = 0;

  beat_t q0[$];
  beat_t q1[$];

  // Reference model state, one slot per instance
  int m_st[2];
  int m_cnt[2];
  int m_gap[2];
  int m_drops[2];
  int m_frames[2];
  bit m_hv[2];
  bit m_heop[2];
  bit m_inv[2];
  bit m_ovr[2];

  fft_sink_framer_if #(.DATA_W(DW)) sif0 ();
  fft_sink_framer_if #(.DATA_W(DW)) sif1 ();
  assign sif0.sink_ready = ready;
  assign sif1.sink_ready = ready;

  fft_sink_framer #(.DATA_W(DW), .FFT_LEN(LEN), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .inverse_req(inverse_req),
    .clr_status(clr_status), .in_valid(in_valid), .in_data(in_data), .sink(sif0),
    .inverse(inverse0), .fft_pts(pts0), .busy(busy0), .overrun(ovr0),
    .drop_count(drops0), .frames_done(frames0)
  );

  fft_sink_framer #(.DATA_W(DW), .FFT_LEN(LEN), .GAP_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .inverse_req(inverse_req),
    .clr_status(clr_status), .in_valid(in_valid), .in_data(in_data), .sink(sif1),
    .inverse(inverse1), .fft_pts(pts1), .busy(busy1), .overrun(ovr1),
    .drop_count(drops1), .frames_done(frames1)
  );

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s inst%0d got %0h want %0h", name, i, act, exp);
    end
  endtask

  task automatic push(input int i, input beat_t b);
    if (i == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  // Frame-level model: a frame is LEN loaded samples, a sample is lost when the
  // single output slot is occupied and not draining this cycle.
  task automatic model_step(input int i);
    bit    acc;
    bit    drop;
    beat_t b;
    acc  = m_hv[i] && ready;
    drop = 1'b0;
    if (rst) begin
      m_st[i] = 0; m_cnt[i] = 0; m_gap[i] = 0; m_drops[i] = 0; m_frames[i] = 0;
      m_hv[i] = 0; m_heop[i] = 0; m_inv[i] = 0; m_ovr[i] = 0;
      if (i == 0) q0.delete();
      else        q1.delete();
      return;
    end
    case (m_st[i])
      0: begin
        if (enable && in_valid) begin
          b = {in_data, 1'b1, 1'b0, inverse_req};
          push(i, b);
          m_inv[i] = inverse_req; m_cnt[i] = 1; m_hv[i] = 1; m_heop[i] = 0; m_st[i] = 1;
        end
      end
      1: begin
        if (acc && m_heop[i]) begin
          m_frames[i] = (m_frames[i] + 1) % 65536;
          m_hv[i]     = 0;
          m_gap[i]    = 0;
          m_st[i]     = (gap_of(i) > 0) ? 2 : 0;
        end else if (in_valid && (!m_hv[i] || acc)) begin
          b = {in_data, m_cnt[i] == 0, m_cnt[i] == LEN - 1, m_inv[i]};
          push(i, b);
          m_heop[i] = (m_cnt[i] == LEN - 1);
          m_cnt[i]  = (m_cnt[i] + 1) % LEN;
          m_hv[i]   = 1;
        end else begin
          if (acc) m_hv[i] = 0;
          drop = in_valid;
        end
      end
      default: begin
        m_gap[i]++;
        if (m_gap[i] == gap_of(i)) m_st[i] = 0;
      end
    endcase
    if (clr_status) begin
      m_ovr[i] = 0; m_drops[i] = 0;
    end else if (drop) begin
      m_ovr[i] = 1;
      if (m_drops[i] < 65535) m_drops[i]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic mon(input int i, input logic valid, input logic sop, input logic eop,
                     input logic [DW-1:0] re, input logic [DW-1:0] im, input logic [1:0] err,
                     input logic inv, input logic [3:0] pts, input logic bsy, input logic ovr,
                     input logic [15:0] drops, input logic [15:0] frames);
    beat_t b;
    chk("sink_valid", i, 32'(valid), 32'(m_hv[i]));
    chk("busy", i, 32'(bsy), 32'(m_st[i] != 0));
    chk("overrun", i, 32'(ovr), 32'(m_ovr[i]));
    chk("drop_count", i, 32'(drops), 32'(m_drops[i]));
    chk("frames_done", i, 32'(frames), 32'(m_frames[i]));
    chk("inverse", i, 32'(inv), 32'(m_inv[i]));
    chk("sink_imag", i, 32'(im), 32'(0));
    chk("sink_error", i, 32'(err), 32'(0));
    chk("fft_pts", i, 32'(pts), 32'(LEN));
    if (valid === 1'b1 && ready) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        if (errors <= 20) $display("FAIL beat_unexpected inst%0d got beat data %0h want none", i, re);
      end else begin
        b = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk("beat_data", i, 32'(re), 32'(b.d));
        chk("beat_sop", i, 32'(sop), 32'(b.sop));
        chk("beat_eop", i, 32'(eop), 32'(b.eop));
        chk("beat_inverse", i, 32'(inv), 32'(b.inv));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, sif0.sink_valid, sif0.sink_sop, sif0.sink_eop, sif0.sink_real, sif0.sink_imag,
        sif0.sink_error, inverse0, pts0, busy0, ovr0, drops0, frames0);
    mon(1, sif1.sink_valid, sif1.sink_sop, sif1.sink_eop, sif1.sink_real, sif1.sink_imag,
        sif1.sink_error, inverse1, pts1, busy1, ovr1, drops1, frames1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; inverse_req = 1'b0; clr_status = 1'b0;
    in_valid = 1'b0; ready = 1'b0; in_data = '0;
    repeat (3) step();
    rst = 1'b0;

    // Continuous stream, no backpressure
    enable = 1'b1; ready = 1'b1; in_valid = 1'b1;
    repeat (40) begin
      in_data = DW'($urandom);
      step();
    end

    // Fully randomized traffic, mode and control
    repeat (3000) begin
      in_valid    = ($urandom_range(0, 9) < 8);
      ready       = ($urandom_range(0, 9) < 7);
      enable      = ($urandom_range(0, 19) != 0);
      inverse_req = 1'($urandom_range(0, 1));
      clr_status  = ($urandom_range(0, 19) == 0);
      in_data     = DW'($urandom);
      step();
    end

    // Three-clock stalls with a sample every clock
    enable = 1'b1; in_valid = 1'b1; clr_status = 1'b0;
    for (int k = 0; k < 200; k++) begin
      ready       = ((k % 10) >= 3);
      inverse_req = ((k % 8) == 3);
      in_data     = DW'($urandom);
      step();
    end

    // Reset mid-frame, then restart
    for (int r = 0; r < 6; r++) begin
      ready = 1'b1; in_valid = 1'b1;
      repeat ($urandom_range(3, 20)) begin
        in_data = DW'($urandom);
        step();
      end
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
    end

    // Drops with periodic clears, then saturation
    ready = 1'b0; in_valid = 1'b1; enable = 1'b1;
    for (int k = 0; k < 60; k++) begin
      clr_status = ((k % 7) == 6);
      step();
    end
    clr_status = 1'b0;
    repeat (70010) step();
    chk("drop_sat", 0, 32'(drops0), 32'hFFFF);
    chk("drop_sat", 1, 32'(drops1), 32'hFFFF);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    ready = 1'b1;
    repeat (50) begin
      in_data = DW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
